// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Programmable serial bit-pattern detector controller (2..PAT_W
//               bits) with a Mealy match pulse, match counter and target stop.
//               Optional macro SEQ_OVERLAP_EN enables overlapping matches.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             dout,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_SEARCH = 1'b1;

`ifdef SEQ_OVERLAP_EN
    localparam logic c_CLEAR_ON_MATCH = 1'b0;
`else
    localparam logic c_CLEAR_ON_MATCH = 1'b1;
`endif

    logic [0:0]       state_q, state_d;
    logic             loaded_q, loaded_d;
    logic             ready_q;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic [PAT_W-1:0] w_window;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_len_m1;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_len_ok;
    logic             w_match;

    // Newest bit sits at position 0, so the window lines up with the pattern LSB.
    assign w_window  = {hist_q, in};
    assign w_mask    = ~({PAT_W{1'b1}} << len_q);
    assign w_len_m1  = len_q - LEN_W'(1);
    assign w_cnt_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    assign w_len_ok  = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(PAT_W));
    assign w_match   = (state_q == c_SEARCH) && in_valid && (fill_q >= w_len_m1)
                       && (((w_window ^ pat_q) & w_mask) == '0);

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        pat_d    = pat_q;
        len_d    = len_q;
        target_d = target_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        count_d  = count_q;
        done_d   = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (cfg_valid && ready_q) begin
                    pat_d    = cfg_pattern;
                    len_d    = w_len_ok ? cfg_len : LEN_W'(PAT_W);
                    target_d = cfg_target;
                    loaded_d = 1'b1;
                end else if (start && loaded_q && !abort) begin
                    hist_d  = '0;
                    fill_d  = '0;
                    count_d = '0;
                    state_d = c_SEARCH;
                end
            end
            c_SEARCH: begin
                if (in_valid) begin
                    hist_d = w_window[PAT_W-2:0];
                    if (fill_q < w_len_m1) fill_d = fill_q + LEN_W'(1);
                end
                if (w_match) begin
                    count_d = w_cnt_inc;
                    if (c_CLEAR_ON_MATCH) begin
                        hist_d = '0;
                        fill_d = '0;
                    end
                    // An abort on the final match still counts it but suppresses done.
                    if ((target_q != '0) && (w_cnt_inc == target_q) && !abort) begin
                        done_d  = 1'b1;
                        state_d = c_IDLE;
                    end
                end
                if (abort) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_IDLE;
            loaded_q <= 1'b0;
            ready_q  <= 1'b0;
            pat_q    <= '0;
            len_q    <= LEN_W'(PAT_W);
            target_q <= '0;
            hist_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            ready_q  <= (state_d == c_IDLE);
            pat_q    <= pat_d;
            len_q    <= len_d;
            target_q <= target_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign dout        = w_match;
    assign match_count = count_q;
    assign busy        = (state_q == c_SEARCH);
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_ctrl
// Description : Directed self-checking bench for seq_detect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       in_b;
    logic       dout;
    logic [7:0] match_count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in          (in_b),
        .dout        (dout),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic exp_dout, input string tag);
        in_valid = 1'b1;
        in_b     = b;
        #3;
        chk(tag, {31'd0, dout}, {31'd0, exp_dout});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap(input string tag);
        in_valid = 1'b0;
        in_b     = 1'b1;
        #3;
        chk(tag, {31'd0, dout}, 32'd0);
        tick();
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_target  = tgt;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_b = 1'b0;
        tick(); tick();
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_count", {24'd0, match_count}, 32'd0);
        chk("rst_dout",  {31'd0, dout}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);

        // Start before any config is ignored
        do_start();
        chk("start_unloaded_busy", {31'd0, busy}, 32'd0);

        // Basic 1101 detection
        load(8'h0D, 4'd4, 8'd0);
        do_start();
        chk("basic_busy", {31'd0, busy}, 32'd1);
        chk("basic_ready", {31'd0, cfg_ready}, 32'd0);
        chk("basic_count0", {24'd0, match_count}, 32'd0);
        send(1'b1, 1'b0, "basic_b1");
        send(1'b1, 1'b0, "basic_b2");
        send(1'b0, 1'b0, "basic_b3");
        send(1'b1, 1'b1, "basic_b4");
        chk("basic_count", {24'd0, match_count}, 32'd1);

        // Overlap behaviour on 1101101
        do_abort();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        do_start();
        chk("ovl_count0", {24'd0, match_count}, 32'd0);
        send(1'b1, 1'b0, "ovl_b1");
        send(1'b1, 1'b0, "ovl_b2");
        send(1'b0, 1'b0, "ovl_b3");
        send(1'b1, 1'b1, "ovl_b4");
        send(1'b1, 1'b0, "ovl_b5");
        send(1'b0, 1'b0, "ovl_b6");
`ifdef SEQ_OVERLAP_EN
        send(1'b1, 1'b1, "ovl_b7");
        chk("ovl_count", {24'd0, match_count}, 32'd2);
`else
        send(1'b1, 1'b0, "ovl_b7");
        chk("ovl_count", {24'd0, match_count}, 32'd1);
`endif

        // Target = 2 : 1101 0 1101 then 1101 after stop
        do_abort();
        load(8'h0D, 4'd4, 8'd2);
        do_start();
        send(1'b1, 1'b0, "tgt_b1");
        send(1'b1, 1'b0, "tgt_b2");
        send(1'b0, 1'b0, "tgt_b3");
        send(1'b1, 1'b1, "tgt_b4");
        send(1'b0, 1'b0, "tgt_b5");
        send(1'b1, 1'b0, "tgt_b6");
        send(1'b1, 1'b0, "tgt_b7");
        send(1'b0, 1'b0, "tgt_b8");
        chk("tgt_done_early", {31'd0, done}, 32'd0);
        send(1'b1, 1'b1, "tgt_b9");
        chk("tgt_done", {31'd0, done}, 32'd1);
        chk("tgt_idle", {31'd0, busy}, 32'd0);
        chk("tgt_count", {24'd0, match_count}, 32'd2);
        chk("tgt_ready", {31'd0, cfg_ready}, 32'd1);
        send(1'b1, 1'b0, "tgt_c1");
        chk("tgt_done_pulse", {31'd0, done}, 32'd0);
        send(1'b1, 1'b0, "tgt_c2");
        send(1'b0, 1'b0, "tgt_c3");
        send(1'b1, 1'b0, "tgt_c4");
        chk("tgt_count_hold", {24'd0, match_count}, 32'd2);

        // in_valid gaps carry garbage bits that must be ignored
        load(8'h0D, 4'd4, 8'd0);
        do_start();
        send(1'b1, 1'b0, "gap_b1");
        gap("gap_g1");
        send(1'b1, 1'b0, "gap_b2");
        gap("gap_g2");
        send(1'b0, 1'b0, "gap_b3");
        gap("gap_g3");
        send(1'b1, 1'b1, "gap_b4");
        chk("gap_count", {24'd0, match_count}, 32'd1);

        // Illegal length clamps to 8: A5 needs all 8 bits
        do_abort();
        load(8'hA5, 4'd1, 8'd0);
        do_start();
        send(1'b1, 1'b0, "clamp_b1");
        send(1'b0, 1'b0, "clamp_b2");
        send(1'b1, 1'b0, "clamp_b3");
        send(1'b0, 1'b0, "clamp_b4");
        send(1'b0, 1'b0, "clamp_b5");
        send(1'b1, 1'b0, "clamp_b6");
        send(1'b0, 1'b0, "clamp_b7");
        send(1'b1, 1'b1, "clamp_b8");
        chk("clamp_count", {24'd0, match_count}, 32'd1);

        // Abort on the completing bit
        do_abort();
        load(8'h0D, 4'd4, 8'd1);
        do_start();
        send(1'b1, 1'b0, "abm_b1");
        send(1'b1, 1'b0, "abm_b2");
        send(1'b0, 1'b0, "abm_b3");
        abort = 1'b1;
        send(1'b1, 1'b1, "abm_b4");
        abort = 1'b0;
        chk("abm_count", {24'd0, match_count}, 32'd1);
        chk("abm_idle", {31'd0, busy}, 32'd0);
        chk("abm_done", {31'd0, done}, 32'd0);
        tick();
        chk("abm_done_later", {31'd0, done}, 32'd0);

        // Reset mid-search clears the loaded config
        load(8'h0D, 4'd4, 8'd0);
        do_start();
        send(1'b1, 1'b0, "rms_b1");
        send(1'b1, 1'b0, "rms_b2");
        rst = 1'b1;
        tick();
        chk("rms_busy",  {31'd0, busy}, 32'd0);
        chk("rms_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rms_done",  {31'd0, done}, 32'd0);
        chk("rms_count", {24'd0, match_count}, 32'd0);
        chk("rms_dout",  {31'd0, dout}, 32'd0);
        rst = 1'b0;
        tick();
        do_start();
        chk("rms_start_ignored", {31'd0, busy}, 32'd0);

        // Config and start together: config taken, start ignored
        cfg_valid = 1'b1; cfg_pattern = 8'h0D; cfg_len = 4'd4; cfg_target = 8'd0;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        chk("cfgstart_busy", {31'd0, busy}, 32'd0);
        do_start();
        chk("cfgstart_then_busy", {31'd0, busy}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
